// File: rtl/x64_adc_demux_adc_streams.sv
// ---------------------------------------------------------------------------
// x64_adc_demux_adc_streams
//
// Receive-side frame reassembler for the x64 ADC stream multiplexer. It
// takes the serialised 24-bit word stream, finds frame starts from the
// sync marker and collects four words into one 96-bit parallel frame.
// It also tracks alignment and reports frames that are aborted either
// by an early sync or by too long an idle gap inside a frame.
//
// Parameters:
//   GAP_MAX   - max consecutive idle cycles tolerated inside a frame
//               (0 disables the gap timeout)
//
// Ports:
//   clk       - clock
//   rst       - asynchronous active-high reset
//   din       - serial 24-bit data word
//   dinvld    - din valid this cycle
//   din_sync  - frame start marker, qualified by dinvld (lane 0)
//   dout      - assembled frame, lane k at [24k+23:24k]
//   doutvld   - one-cycle pulse, dout holds a new frame
//   frame_err - one-cycle pulse, a frame was aborted
//   locked    - high after a complete frame, cleared on abort
//   err_count - saturating abort counter
//
// Build option:
//   X64_ADC_DEMUX_ERRCNT_EN - when defined, err_count counts frame_err
//                             pulses (saturating at 16'hFFFF); otherwise
//                             err_count is tied to zero.
// ---------------------------------------------------------------------------
module x64_adc_demux_adc_streams #(
    parameter int unsigned GAP_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] din,
    input  logic        dinvld,
    input  logic        din_sync,
    output logic [95:0] dout,
    output logic        doutvld,
    output logic        frame_err,
    output logic        locked,
    output logic [15:0] err_count
);

    localparam int unsigned GW = (GAP_MAX == 0) ? 1 : $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LIM = GW'(GAP_MAX);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [GW-1:0] gap_inc;
    logic [95:0]   asm_q, asm_d;
    logic [95:0]   dout_q, dout_d;
    logic          doutvld_q, doutvld_d;
    logic          frame_err_q, frame_err_d;
    logic          locked_q, locked_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        asm_d       = asm_q;
        dout_d      = dout_q;
        doutvld_d   = 1'b0;
        frame_err_d = 1'b0;
        locked_d    = locked_q;
        gap_inc     = gap_q + 1'b1;

        case (state_q)
            HUNT: begin
                // Unsynchronised valid words are dropped silently here.
                if (dinvld && din_sync) begin
                    asm_d[23:0] = din;
                    idx_d       = 2'd1;
                    gap_d       = '0;
                    state_d     = COLLECT;
                end
            end

            COLLECT: begin
                if (dinvld) begin
                    gap_d = '0;
                    if (din_sync) begin
                        // Early sync: abort, but the word starts a new frame.
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        asm_d[23:0] = din;
                        idx_d       = 2'd1;
                    end else if (idx_q == 2'd3) begin
                        // Lane 3 goes straight to dout, bypassing asm_q.
                        dout_d    = {din, asm_q[71:0]};
                        doutvld_d = 1'b1;
                        locked_d  = 1'b1;
                        idx_d     = 2'd0;
                        state_d   = HUNT;
                    end else begin
                        asm_d[32'(idx_q) * 24 +: 24] = din;
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    gap_d = gap_inc;
                    if ((GAP_MAX != 0) && (gap_inc == GAP_LIM)) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        idx_d       = 2'd0;
                        gap_d       = '0;
                        state_d     = HUNT;
                    end
                end
            end

            default: begin
                state_d = HUNT;
                idx_d   = 2'd0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= 2'd0;
            gap_q       <= '0;
            asm_q       <= '0;
            dout_q      <= '0;
            doutvld_q   <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            asm_q       <= asm_d;
            dout_q      <= dout_d;
            doutvld_q   <= doutvld_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

    assign dout      = dout_q;
    assign doutvld   = doutvld_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;

`ifdef X64_ADC_DEMUX_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Counts on the same edge that registers frame_err, so both appear together.
    always_comb begin
        err_count_d = err_count_q;
        if (frame_err_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_x64_adc_demux_adc_streams.sv
// ---------------------------------------------------------------------------
// tb_x64_adc_demux_adc_streams
//
// Bench for x64_adc_demux_adc_streams (GAP_MAX = 4). A table of per-cycle
// input/expected-output records covers aligned, back-to-back, unaligned,
// early-sync and gap-timeout frames; assembled frames go through a
// scoreboard queue. Reset mid-frame and the abort-counter storm are
// written out by hand. Honours X64_ADC_DEMUX_ERRCNT_EN for err_count.
// ---------------------------------------------------------------------------
module tb_x64_adc_demux_adc_streams;

`ifdef X64_ADC_DEMUX_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int STORM = CNT_EN ? 65537 : 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] din = '0;
    logic        dinvld = 1'b0;
    logic        din_sync = 1'b0;
    logic [95:0] dout;
    logic        doutvld;
    logic        frame_err;
    logic        locked;
    logic [15:0] err_count;

    x64_adc_demux_adc_streams #(.GAP_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dinvld    (dinvld),
        .din_sync  (din_sync),
        .dout      (dout),
        .doutvld   (doutvld),
        .frame_err (frame_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        sync;
        logic [23:0] data;
        logic        exp_vld;
        logic        exp_err;
        logic        exp_lock;
        logic [95:0] frame;
    } vec_t;

    vec_t        vecs[$];
    logic [95:0] sb[$];
    logic [95:0] exp_dout = '0;
    logic [15:0] exp_errs = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic s, input logic [23:0] d,
                                input logic ev, input logic ee, input logic el,
                                input logic [95:0] fr);
        vec_t r;
        r.vld = v; r.sync = s; r.data = d;
        r.exp_vld = ev; r.exp_err = ee; r.exp_lock = el; r.frame = fr;
        vecs.push_back(r);
    endfunction

    // Drive one cycle, then check the outputs #1 after the sampling edge.
    task automatic step(input logic v, input logic s, input logic [23:0] d,
                        input logic ev, input logic ee, input logic el,
                        input logic [95:0] fr);
        logic [95:0] want;
        dinvld = v; din_sync = s; din = d;
        if (ev) sb.push_back(fr);
        @(posedge clk);
        #1;
        if (ee && exp_errs != 16'hFFFF) exp_errs++;
        chk("doutvld", 96'(doutvld), 96'(ev));
        chk("frame_err", 96'(frame_err), 96'(ee));
        chk("locked", 96'(locked), 96'(el));
        chk("excl", 96'(doutvld & frame_err), 96'(0));
        if (doutvld) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", dout, exp_dout);
            end else begin
                want = sb.pop_front();
                chk("dout_frame", dout, want);
                exp_dout = want;
            end
        end else begin
            chk("dout_hold", dout, exp_dout);
        end
        chk("err_count", 96'(err_count), 96'(CNT_EN ? exp_errs : 16'h0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Aligned contiguous frame, then a back-to-back one.
        add(1, 1, 24'h000001, 0, 0, 0, '0);
        add(1, 0, 24'h000002, 0, 0, 0, '0);
        add(1, 0, 24'h000003, 0, 0, 0, '0);
        add(1, 0, 24'h000004, 1, 0, 1, 96'h000004_000003_000002_000001);
        add(1, 1, 24'h000011, 0, 0, 1, '0);
        add(1, 0, 24'h000012, 0, 0, 1, '0);
        add(1, 0, 24'h000013, 0, 0, 1, '0);
        add(1, 0, 24'h000014, 1, 0, 1, 96'h000014_000013_000012_000011);
        // Unaligned words dropped in HUNT, then a proper frame.
        add(1, 0, 24'h0000AA, 0, 0, 1, '0);
        add(1, 0, 24'h0000BB, 0, 0, 1, '0);
        add(0, 0, 24'h000000, 0, 0, 1, '0);
        add(1, 1, 24'h000021, 0, 0, 1, '0);
        add(1, 0, 24'h000022, 0, 0, 1, '0);
        add(1, 0, 24'h000023, 0, 0, 1, '0);
        add(1, 0, 24'h000024, 1, 0, 1, 96'h000024_000023_000022_000021);
        // Early sync: A, B aborted by sync+C; frame {F,E,D,C}.
        add(1, 1, 24'h000031, 0, 0, 1, '0);
        add(1, 0, 24'h000032, 0, 0, 1, '0);
        add(1, 1, 24'h000033, 0, 1, 0, '0);
        add(1, 0, 24'h000034, 0, 0, 0, '0);
        add(1, 0, 24'h000035, 0, 0, 0, '0);
        add(1, 0, 24'h000036, 1, 0, 1, 96'h000036_000035_000034_000033);
        // Gap timeout after four idle cycles, following word dropped.
        add(1, 1, 24'h000041, 0, 0, 1, '0);
        add(1, 0, 24'h000042, 0, 0, 1, '0);
        add(0, 0, 24'h000000, 0, 0, 1, '0);
        add(0, 0, 24'h000000, 0, 0, 1, '0);
        add(0, 0, 24'h000000, 0, 0, 1, '0);
        add(0, 0, 24'h000000, 0, 1, 0, '0);
        add(1, 0, 24'h000043, 0, 0, 0, '0);
        add(0, 1, 24'h000044, 0, 0, 0, '0);
        // Three idle cycles (one with unqualified sync) are tolerated.
        add(1, 1, 24'h000051, 0, 0, 0, '0);
        add(1, 0, 24'h000052, 0, 0, 0, '0);
        add(0, 0, 24'h000000, 0, 0, 0, '0);
        add(0, 1, 24'h0000EE, 0, 0, 0, '0);
        add(0, 0, 24'h000000, 0, 0, 0, '0);
        add(1, 0, 24'h000053, 0, 0, 0, '0);
        add(1, 0, 24'h000054, 1, 0, 1, 96'h000054_000053_000052_000051);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 96'h0);
        chk("rst_doutvld", 96'(doutvld), 96'(0));
        chk("rst_frame_err", 96'(frame_err), 96'(0));
        chk("rst_locked", 96'(locked), 96'(0));
        chk("rst_err_count", 96'(err_count), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].sync, vecs[i].data,
                 vecs[i].exp_vld, vecs[i].exp_err, vecs[i].exp_lock, vecs[i].frame);
        end

        // Reset mid-frame: partial frame discarded, later lanes dropped.
        step(1, 1, 24'h000061, 0, 0, 1, '0);
        step(1, 0, 24'h000062, 0, 0, 1, '0);
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", dout, 96'h0);
        chk("mid_rst_locked", 96'(locked), 96'(0));
        chk("mid_rst_err_count", 96'(err_count), 96'(0));
        exp_dout = '0;
        exp_errs = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 24'h000063, 0, 0, 0, '0);
        step(1, 0, 24'h000064, 0, 0, 0, '0);
        step(0, 0, 24'h000000, 0, 0, 0, '0);

        // Abort storm: sync on every valid cycle, first one only opens a frame.
        dinvld = 1'b1;
        din_sync = 1'b1;
        for (int i = 0; i <= STORM; i++) begin
            din = 24'(i);
            @(posedge clk);
        end
        #1;
        chk("storm_err_count", 96'(err_count), 96'(CNT_EN ? 16'hFFFF : 16'h0));
        chk("storm_frame_err", 96'(frame_err), 96'(1));
        chk("storm_locked", 96'(locked), 96'(0));
        chk("storm_dout", dout, exp_dout);
        exp_errs = 16'hFFFF;
        step(1, 1, 24'h000071, 0, 1, 0, '0);
        step(0, 0, 24'h000000, 0, 0, 0, '0);

        rst = 1'b1;
        #1;
        chk("final_rst_err_count", 96'(err_count), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("sb_empty", 96'(sb.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
